sel_ctrl: RTL and testbench

SEL_CTRL -- requirements
Module: sel_ctrl

---
 rtl/sel_ctrl.sv | 158 +++++++++++++++
 tb/tb_sel_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/sel_ctrl.sv
// sel_ctrl: two debounced push-buttons steering a 2-bit operand loader.
//   btnSel toggles the mux select between operand registers a and b.
//   btnLoad captures sw into whichever register the select points at.
// Optional feature macro: SEL_CTRL_LOAD_CNT_EN enables the saturating
// loadCount; without it loadCount is tied to 8'd0.
//
// state | meaning
// SEL_A | control=0, loads write a
// SEL_B | control=1, loads write b

// Per-button synchronizer, debouncer and rising-edge event generator.
module sel_ctrl_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic i_raw,
    output logic o_evt
);

    logic        r_sync1;
    logic        r_sync2;
    logic        r_level;
    logic        r_level_d;
    logic [15:0] r_cnt;
    logic [16:0] w_cnt_next;
    logic        w_hit;

    assign w_cnt_next = {1'b0, r_cnt} + 17'd1;
    assign w_hit      = (w_cnt_next == 17'(DEBOUNCE_CYCLES));

    // Two-flop synchronizer for the asynchronous raw button.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Count consecutive disagreements; flip the level once the run is long enough.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt     <= 16'd0;
            r_level   <= 1'b0;
            r_level_d <= 1'b0;
        end else begin
            r_level_d <= r_level;
            if (r_sync2 == r_level) begin
                r_cnt <= 16'd0;
            end else if (w_hit) begin
                r_level <= ~r_level;
                r_cnt   <= 16'd0;
            end else begin
                r_cnt <= w_cnt_next[15:0];
            end
        end
    end

    // Only a press (rising debounced level) is an event; r_level_d resets low
    // so a button held through reset release still yields exactly one event.
    assign o_evt = r_level & ~r_level_d;

endmodule

module sel_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btnSel,
    input  logic       btnLoad,
    input  logic [1:0] sw,
    output logic [1:0] a,
    output logic [1:0] b,
    output logic       control,
    output logic       loadDone,
    output logic [7:0] loadCount
);

    typedef enum logic {
        SEL_A = 1'b0,
        SEL_B = 1'b1
    } state_t;

    state_t     r_state;
    logic [1:0] r_a;
    logic [1:0] r_b;
    logic       r_load_done;
    logic       w_sel_evt;
    logic       w_load_evt;

    sel_ctrl_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_sel (
        .clk   (clk),
        .reset (reset),
        .i_raw (btnSel),
        .o_evt (w_sel_evt)
    );

    sel_ctrl_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_load (
        .clk   (clk),
        .reset (reset),
        .i_raw (btnLoad),
        .o_evt (w_load_evt)
    );

    // Select FSM plus operand registers; a simultaneous load uses the
    // pre-toggle state because both read r_state before this edge updates it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= SEL_A;
            r_a         <= 2'b00;
            r_b         <= 2'b00;
            r_load_done <= 1'b0;
        end else begin
            r_load_done <= w_load_evt;
            if (w_load_evt) begin
                if (r_state == SEL_A) begin
                    r_a <= sw;
                end else begin
                    r_b <= sw;
                end
            end
            if (w_sel_evt) begin
                case (r_state)
                    SEL_A:   r_state <= SEL_B;
                    SEL_B:   r_state <= SEL_A;
                    default: r_state <= SEL_A;
                endcase
            end
        end
    end

    assign a        = r_a;
    assign b        = r_b;
    assign control  = (r_state == SEL_B);
    assign loadDone = r_load_done;

`ifdef SEL_CTRL_LOAD_CNT_EN
    logic [7:0] r_load_cnt;

    // Saturating count of load events.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_load_cnt <= 8'd0;
        end else if (w_load_evt && (r_load_cnt != 8'd255)) begin
            r_load_cnt <= r_load_cnt + 8'd1;
        end
    end

    assign loadCount = r_load_cnt;
`else
    assign loadCount = 8'd0;
`endif

endmodule

// File: tb/tb_sel_ctrl.sv
// Bench for sel_ctrl with DEBOUNCE_CYCLES=4. A raw-domain reference model
// (run-length of raw samples plus a fixed effect delay) is compared every
// cycle; directed literal checks pin the model to the stated latencies.
module tb_sel_ctrl;

    localparam int D = 4;

    logic       clk;
    logic       reset;
    logic       btnSel;
    logic       btnLoad;
    logic [1:0] sw;
    logic [1:0] a;
    logic [1:0] b;
    logic       control;
    logic       loadDone;
    logic [7:0] loadCount;

    int n_cmp = 0;
    int n_err = 0;

    sel_ctrl #(.DEBOUNCE_CYCLES(D)) dut (
        .clk       (clk),
        .reset     (reset),
        .btnSel    (btnSel),
        .btnLoad   (btnLoad),
        .sw        (sw),
        .a         (a),
        .b         (b),
        .control   (control),
        .loadDone  (loadDone),
        .loadCount (loadCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model. A raw level counts as "pressed" once D consecutive
    // edge samples disagree with the current level; the visible effect
    // lands 3 edges after the last of those samples (2 sync + 1 event edge).
    logic [1:0] m_a, m_b;
    logic       m_ctl, m_done;
    int         m_cnt;
    int         m_run  [2];
    logic       m_lvl  [2];
    logic [2:0] m_pipe [2];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_a = 2'b00; m_b = 2'b00; m_ctl = 1'b0; m_done = 1'b0; m_cnt = 0;
            for (int i = 0; i < 2; i++) begin
                m_run[i] = 0; m_lvl[i] = 1'b0; m_pipe[i] = 3'b000;
            end
        end else begin
            logic raw [2];
            m_done = 1'b0;
            if (m_pipe[1][2]) begin
                if (m_ctl == 1'b0) m_a = sw; else m_b = sw;
                m_done = 1'b1;
                if (m_cnt < 255) m_cnt = m_cnt + 1;
            end
            if (m_pipe[0][2]) m_ctl = ~m_ctl;
            raw[0] = btnSel;
            raw[1] = btnLoad;
            for (int i = 0; i < 2; i++) begin
                m_pipe[i] = {m_pipe[i][1:0], 1'b0};
                if (raw[i] != m_lvl[i]) begin
                    m_run[i] = m_run[i] + 1;
                    if (m_run[i] == D) begin
                        m_lvl[i] = raw[i];
                        m_run[i] = 0;
                        if (raw[i]) m_pipe[i][0] = 1'b1;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int exp_count();
`ifdef SEL_CTRL_LOAD_CNT_EN
        return m_cnt;
`else
        return 0;
`endif
    endfunction

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        check("model_a", int'(a), int'(m_a));
        check("model_b", int'(b), int'(m_b));
        check("model_control", int'(control), int'(m_ctl));
        check("model_loadDone", int'(loadDone), int'(m_done));
        check("model_loadCount", int'(loadCount), exp_count());
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press_load(input int hold, input int gap);
        btnLoad = 1'b1; tick(hold);
        btnLoad = 1'b0; tick(gap);
    endtask

    task automatic press_sel(input int hold, input int gap);
        btnSel = 1'b1; tick(hold);
        btnSel = 1'b0; tick(gap);
    endtask

    initial begin
        reset = 1'b1; btnSel = 1'b0; btnLoad = 1'b0; sw = 2'b00;
        tick(3);
        check("rst_control", int'(control), 0);
        check("rst_a", int'(a), 0);
        check("rst_b", int'(b), 0);
        check("rst_loadDone", int'(loadDone), 0);
        check("rst_loadCount", int'(loadCount), 0);
        reset = 1'b0;
        tick(2);

        // Held select press: first sampled at edge N, toggle at N+6.
        btnSel = 1'b1;
        tick(6);
        check("sel_lat_before", int'(control), 0);
        tick(1);
        check("sel_lat_at", int'(control), 1);
        tick(3);
        btnSel = 1'b0;
        tick(12);
        check("sel_held_once", int'(control), 1);

        // Bounce shorter than D on the load button: nothing happens.
        btnLoad = 1'b1; tick(2);
        btnLoad = 1'b0; tick(2);
        btnLoad = 1'b1; tick(3);
        btnLoad = 1'b0; tick(12);
        check("bounce_a", int'(a), 0);
        check("bounce_b", int'(b), 0);
        check("bounce_control", int'(control), 1);

        // Back to SEL_A, then load a.
        press_sel(8, 10);
        check("back_to_a", int'(control), 0);
        sw = 2'b10;
        btnLoad = 1'b1;
        tick(6);
        check("load_a_before", int'(a), 0);
        tick(1);
        check("load_a_val", int'(a), 2);
        check("load_a_b_held", int'(b), 0);
        check("load_a_done", int'(loadDone), 1);
        tick(1);
        check("load_a_done_end", int'(loadDone), 0);
        tick(2);
        btnLoad = 1'b0;
        tick(10);

        // SEL_B, load b.
        press_sel(8, 10);
        sw = 2'b11;
        press_load(8, 10);
        check("load_b_val", int'(b), 3);
        check("load_b_a_held", int'(a), 2);

        // Back to SEL_A, simultaneous select and load.
        press_sel(8, 10);
        sw = 2'b01;
        btnSel = 1'b1; btnLoad = 1'b1;
        tick(6);
        check("simul_before_ctl", int'(control), 0);
        tick(1);
        check("simul_a", int'(a), 1);
        check("simul_b", int'(b), 3);
        check("simul_ctl", int'(control), 1);
        tick(2);
        btnSel = 1'b0; btnLoad = 1'b0;
        tick(10);

        // Reset mid-press, released while held: full latency from the first
        // edge that samples the held button after release.
        btnSel = 1'b1;
        tick(2);
        reset = 1'b1;
        tick(1);
        check("midrst_control", int'(control), 0);
        check("midrst_a", int'(a), 0);
        check("midrst_b", int'(b), 0);
        check("midrst_loadDone", int'(loadDone), 0);
        check("midrst_loadCount", int'(loadCount), 0);
        tick(2);
        reset = 1'b0;
        tick(6);
        check("postrst_before", int'(control), 0);
        tick(1);
        check("postrst_at", int'(control), 1);
        tick(3);
        btnSel = 1'b0;
        tick(10);

        // Saturation of the load counter.
        for (int i = 0; i < 257; i++) begin
            sw = 2'(i);
            press_load(7, 8);
        end
`ifdef SEL_CTRL_LOAD_CNT_EN
        check("loadcnt_sat", int'(loadCount), 255);
`else
        check("loadcnt_zero", int'(loadCount), 0);
`endif
        check("loadcnt_b_last", int'(b), 0);
        tick(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
